// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM encoding,
// the strobe bundle driven onto the pipeline register bank, and defaults.
package pipe_pkg;

  localparam int REG_W_DEF   = 5;
  localparam int MDU_LAT_DEF = 4;
  localparam int MDU_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MDU_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic ifid_clear;
    logic idex_load;
    logic idex_clear;
    logic exmem_load;
    logic exmem_clear;
    logic memwb_load;
    logic memwb_clear;
  } strobe_t;

  // Canned strobe patterns, one per pipeline condition.
  localparam strobe_t STRB_RUN     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam strobe_t STRB_CLEAR   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam strobe_t STRB_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam strobe_t STRB_MDU     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam strobe_t STRB_BRANCH  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam strobe_t STRB_LOADUSE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  // True when any pipeline register is told to load and clear at once.
  function automatic logic strobe_conflict(input strobe_t s);
    return (s.ifid_load & s.ifid_clear) | (s.idex_load & s.idex_clear) |
           (s.exmem_load & s.exmem_clear) | (s.memwb_load & s.memwb_clear);
  endfunction

endpackage

// File: rtl/pipe_loaduse_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID
// instruction is about to read. Register 0 is hard-wired and never hazards.
module pipe_loaduse_detect
  import pipe_pkg::*;
#(
  parameter int RegW = REG_W_DEF
) (
  input  logic [RegW-1:0] id_rs_i,
  input  logic [RegW-1:0] id_rt_i,
  input  logic            id_uses_rs_i,
  input  logic            id_uses_rt_i,
  input  logic            ex_memread_i,
  input  logic [RegW-1:0] ex_rd_i,
  output logic            hazard_o
);

  logic rs_hit_s;
  logic rt_hit_s;
  logic rd_nonzero_s;

  assign rs_hit_s     = id_uses_rs_i && (id_rs_i == ex_rd_i);
  assign rt_hit_s     = id_uses_rt_i && (id_rt_i == ex_rd_i);
  assign rd_nonzero_s = (ex_rd_i != {RegW{1'b0}});
  assign hazard_o     = ex_memread_i && rd_nonzero_s && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline register bank: resolves
// freeze / MDU / branch / load-use hazards and counts stalled cycles.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int RegW   = REG_W_DEF,
  parameter int MduLat = MDU_LAT_DEF,
  parameter int CntW   = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [RegW-1:0] id_rs,
  input  logic [RegW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [RegW-1:0] ex_rd,
  input  logic            ex_branch_taken,
  input  logic            ex_mdu_start,
  input  logic            mem_busy,
  output logic            pc_load,
  output logic            ifid_load,
  output logic            ifid_clear,
  output logic            idex_load,
  output logic            idex_clear,
  output logic            exmem_load,
  output logic            exmem_clear,
  output logic            memwb_load,
  output logic            memwb_clear,
  output logic [CntW-1:0] stall_cnt
);

  localparam logic [MDU_CNT_W-1:0] MduInit = MDU_CNT_W'(MduLat - 1);
  localparam logic [CntW-1:0]      CntMax  = {CntW{1'b1}};
  localparam logic [CntW-1:0]      CntOne  = {{(CntW-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic [CntW-1:0]        stall_cnt_q, stall_cnt_d;
  logic                   loaduse_s;
  logic                   mdu_stall_s;
  strobe_t                strb_s;

  pipe_loaduse_detect #(
    .RegW(RegW)
  ) u_loaduse (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .hazard_o     (loaduse_s)
  );

  // In MDU_DONE the MDU instruction is leaving EX, so its start flag is stale.
  assign mdu_stall_s = (state_q == ST_MDU_WAIT) ||
                       ((state_q == ST_RUN) && ex_mdu_start);

  // Strobe priority mux: clear > memory freeze > MDU > branch > load-use.
  always_comb begin
    strb_s = STRB_RUN;
    if (clear) begin
      strb_s = STRB_CLEAR;
    end else if (mem_busy) begin
      strb_s = STRB_FREEZE;
    end else if (mdu_stall_s) begin
      strb_s = STRB_MDU;
    end else if (ex_branch_taken) begin
      strb_s = STRB_BRANCH;
    end else if (loaduse_s) begin
      strb_s = STRB_LOADUSE;
    end else begin
      strb_s = STRB_RUN;
    end
  end

  assign pc_load     = strb_s.pc_load;
  assign ifid_load   = strb_s.ifid_load;
  assign ifid_clear  = strb_s.ifid_clear;
  assign idex_load   = strb_s.idex_load;
  assign idex_clear  = strb_s.idex_clear;
  assign exmem_load  = strb_s.exmem_load;
  assign exmem_clear = strb_s.exmem_clear;
  assign memwb_load  = strb_s.memwb_load;
  assign memwb_clear = strb_s.memwb_clear;
  assign stall_cnt   = stall_cnt_q;

  // Next-state logic. The MDU countdown runs even under a memory freeze so
  // the MDU latency is not stretched by data-memory waits.
  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    if (clear) begin
      state_d   = ST_RUN;
      mdu_cnt_d = {MDU_CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_mdu_start && !mem_busy) begin
            if (MduLat == 1) begin
              state_d   = ST_MDU_DONE;
              mdu_cnt_d = {MDU_CNT_W{1'b0}};
            end else begin
              state_d   = ST_MDU_WAIT;
              mdu_cnt_d = MduInit;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MDU_WAIT: begin
          mdu_cnt_d = mdu_cnt_q - 4'd1;
          if (mdu_cnt_q == 4'd1) begin
            state_d = ST_MDU_DONE;
          end else begin
            state_d = ST_MDU_WAIT;
          end
        end
        ST_MDU_DONE: begin
          if (mem_busy) begin
            state_d = ST_MDU_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d   = ST_RUN;
          mdu_cnt_d = {MDU_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      stall_cnt_d = {CntW{1'b0}};
    end else if (!strb_s.pc_load && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; clear is folded into the next-state terms above.
  always_ff @(posedge clock) begin
    state_q     <= state_d;
    mdu_cnt_q   <= mdu_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three instances (MduLat=4, MduLat=1, CntW=4)
// share one stimulus bus; each task checks the instance it targets.
module tb_pipe_ctrl;

  logic       clock = 1'b0;
  logic       clear;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start, mem_busy;

  // Strobe vectors: {pc, ifid_l, ifid_c, idex_l, idex_c, exmem_l, exmem_c, memwb_l, memwb_c}
  logic [8:0]  a_s, b_s, c_s;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  localparam logic [8:0] S_RUN     = 9'b110101010;
  localparam logic [8:0] S_CLEAR   = 9'b001010101;
  localparam logic [8:0] S_FREEZE  = 9'b000000001;
  localparam logic [8:0] S_MDU     = 9'b000000110;
  localparam logic [8:0] S_BRANCH  = 9'b101011010;
  localparam logic [8:0] S_LOADUSE = 9'b000011010;

  int errors = 0;
  int checks = 0;
  logic inv_en = 1'b0;

  always #5 clock = ~clock;

  pipe_ctrl #(.RegW(5), .MduLat(4), .CntW(16)) u_a (
    .clock(clock), .clear(clear), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_busy(mem_busy),
    .pc_load(a_s[8]), .ifid_load(a_s[7]), .ifid_clear(a_s[6]), .idex_load(a_s[5]),
    .idex_clear(a_s[4]), .exmem_load(a_s[3]), .exmem_clear(a_s[2]),
    .memwb_load(a_s[1]), .memwb_clear(a_s[0]), .stall_cnt(a_cnt)
  );

  pipe_ctrl #(.RegW(5), .MduLat(1), .CntW(16)) u_b (
    .clock(clock), .clear(clear), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_busy(mem_busy),
    .pc_load(b_s[8]), .ifid_load(b_s[7]), .ifid_clear(b_s[6]), .idex_load(b_s[5]),
    .idex_clear(b_s[4]), .exmem_load(b_s[3]), .exmem_clear(b_s[2]),
    .memwb_load(b_s[1]), .memwb_clear(b_s[0]), .stall_cnt(b_cnt)
  );

  pipe_ctrl #(.RegW(5), .MduLat(4), .CntW(4)) u_c (
    .clock(clock), .clear(clear), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_busy(mem_busy),
    .pc_load(c_s[8]), .ifid_load(c_s[7]), .ifid_clear(c_s[6]), .idex_load(c_s[5]),
    .idex_clear(c_s[4]), .exmem_load(c_s[3]), .exmem_clear(c_s[2]),
    .memwb_load(c_s[1]), .memwb_clear(c_s[0]), .stall_cnt(c_cnt)
  );

  // Any *_clear must suppress the matching *_load, every cycle.
  always @(negedge clock) begin
    if (inv_en) begin
      checks++;
      if (((a_s[7] & a_s[6]) | (a_s[5] & a_s[4]) | (a_s[3] & a_s[2]) | (a_s[1] & a_s[0])) !== 1'b0) begin
        errors++;
        $display("FAIL invariant_clear_load t=%0t got=%b", $time, a_s);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_CLEAR) begin
      errors++; $display("FAIL clear_strobes got=%b exp=%b", a_s, S_CLEAR);
    end
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN || a_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_state got=%b cnt=%0d exp=%b cnt=0", a_s, a_cnt, S_RUN);
    end
    tick();
  endtask

  task automatic test_reset_mid_mdu();
    do_clear();
    ex_mdu_start = 1'b1;
    tick();
    tick();
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_CLEAR) begin
      errors++; $display("FAIL mid_mdu_clear got=%b exp=%b", a_s, S_CLEAR);
    end
    tick();
    clear = 1'b0;
    ex_mdu_start = 1'b0;
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN || a_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_mdu_after got=%b cnt=%0d exp=%b cnt=0", a_s, a_cnt, S_RUN);
    end
    tick();
  endtask

  task automatic test_loaduse();
    do_clear();
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_LOADUSE) begin
      errors++; $display("FAIL loaduse_rs got=%b exp=%b", a_s, S_LOADUSE);
    end
    tick();
    ex_memread = 1'b0;
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN || a_cnt !== 16'd1) begin
      errors++; $display("FAIL loaduse_one_bubble got=%b cnt=%0d exp=%b cnt=1", a_s, a_cnt, S_RUN);
    end
    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN) begin
      errors++; $display("FAIL loaduse_r0 got=%b exp=%b", a_s, S_RUN);
    end
    tick();
    id_uses_rs = 1'b0; id_rs = 5'd9; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_LOADUSE) begin
      errors++; $display("FAIL loaduse_rt got=%b exp=%b", a_s, S_LOADUSE);
    end
    tick();
    id_uses_rt = 1'b0;
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN || a_cnt !== 16'd2) begin
      errors++; $display("FAIL loaduse_rt_unused got=%b cnt=%0d exp=%b cnt=2", a_s, a_cnt, S_RUN);
    end
    tick();
  endtask

  task automatic test_branch_over_loaduse();
    do_clear();
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_BRANCH) begin
      errors++; $display("FAIL branch_strobes got=%b exp=%b", a_s, S_BRANCH);
    end
    tick();
    idle_inputs();
    checks++;
    if (a_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_no_stall got=%0d exp=0", a_cnt);
    end
  endtask

  task automatic test_mdu();
    do_clear();
    ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (a_s !== S_MDU) begin
        errors++; $display("FAIL mdu4_stall cyc=%0d got=%b exp=%b", i, a_s, S_MDU);
      end
      tick();
    end
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN || a_cnt !== 16'd4) begin
      errors++; $display("FAIL mdu4_done got=%b cnt=%0d exp=%b cnt=4", a_s, a_cnt, S_RUN);
    end
    tick();
    ex_mdu_start = 1'b0;
    do_clear();
    ex_mdu_start = 1'b1;
    @(negedge clock);
    checks++;
    if (b_s !== S_MDU) begin
      errors++; $display("FAIL mdu1_stall got=%b exp=%b", b_s, S_MDU);
    end
    tick();
    @(negedge clock);
    checks++;
    if (b_s !== S_RUN || b_cnt !== 16'd1) begin
      errors++; $display("FAIL mdu1_done got=%b cnt=%0d exp=%b cnt=1", b_s, b_cnt, S_RUN);
    end
    tick();
    ex_mdu_start = 1'b0;
  endtask

  task automatic test_mem_busy_mdu();
    do_clear();
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (a_s !== S_FREEZE) begin
        errors++; $display("FAIL busy_freeze cyc=%0d got=%b exp=%b", i, a_s, S_FREEZE);
      end
      tick();
    end
    mem_busy = 1'b0;
    ex_mdu_start = 1'b1;
    @(negedge clock);
    checks++;
    if (a_s !== S_RUN) begin
      errors++; $display("FAIL busy_mdu_done got=%b exp=%b", a_s, S_RUN);
    end
    tick();
    ex_mdu_start = 1'b0;
    checks++;
    if (a_cnt !== 16'd5) begin
      errors++; $display("FAIL busy_stall_cnt got=%0d exp=5", a_cnt);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (c_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_reach got=%h exp=f", c_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (c_cnt !== 4'hF || a_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_hold got=%h wide=%0d exp=f wide=20", c_cnt, a_cnt);
    end
    mem_busy = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clear = 1'b1;
    tick();
    tick();
    inv_en = 1'b1;
    test_reset();
    test_reset_mid_mdu();
    test_loaduse();
    test_branch_over_loaduse();
    test_mdu();
    test_mem_busy_mdu();
    test_saturation();
    inv_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
